traffic_light_sequencer: RTL and testbench
==========================================

TRAFFIC_LIGHT_SEQUENCER -- requirements
Module: traffic_light_sequencer

Interface
REQ-001 Parameter GREEN_T, 8, green duration in ticks (range 1..15).
REQ-002 Parameter YELLOW_T, 3, yellow duration in ticks (range 1..15).
REQ-003 Parameter ALLRED_T, 1, all-red clearance duration in ticks (range 1..15).
REQ-004 Parameter WALK_T, 6, pedestrian walk duration in ticks (range 1..15).
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 mode  input  2  traffic mode: 00 day, 01 night, 10 pedestrian, 11 emergency; sampled every clk.
REQ-008 tick  input  1  one-clk-wide timebase enable; timers advance only when tick=1.
REQ-009 nsLight  output  3  north-south lamps {R,Y,G}.
REQ-010 ewLight  output  3  east-west lamps {R,Y,G}.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 pedPending  output  1  pedestrian request latched, not yet serviced.
REQ-013 state  output  4  current FSM state code (debug).

Function
REQ-014 FSM states SHALL be: NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, PED_WALK, NIGHT, EMG; all outputs SHALL decode from registered state only (Moore).
REQ-015 Lamp decode SHALL be: NS_G ns=001 ew=100; NS_Y ns=010 ew=100; EW_G ns=100 ew=001; EW_Y ns=100 ew=010; AR1/AR2/PED_WALK/EMG ns=100 ew=100; walk=1 only in PED_WALK.
REQ-016 A 4-bit down-counter SHALL load (duration-1) on every state entry; with tick=1 it decrements; expiry = (count==0 and tick=1); state transitions on expiry occur on that same edge.
REQ-017 Day cycle SHALL be NS_G(GREEN_T) -> NS_Y(YELLOW_T) -> AR1(ALLRED_T) -> EW_G(GREEN_T) -> EW_Y(YELLOW_T) -> AR2(ALLRED_T) -> NS_G.
REQ-018 pedPending SHALL set on any clk with mode=10 (and not in PED_WALK), stay set across mode changes, and clear on the edge entering PED_WALK.
REQ-019 On AR1 or AR2 expiry with pedPending=1 (mode not 11) the FSM SHALL enter PED_WALK for WALK_T, then proceed to the green that would have followed (AR1 -> EW_G, AR2 -> NS_G).
REQ-020 On AR1 or AR2 expiry with mode=01 and pedPending=0 the FSM SHALL enter NIGHT.
REQ-021 In NIGHT a flash bit SHALL reset to 1 on entry and toggle on each tick; ns=flash?010:000, ew=flash?100:000.
REQ-022 NIGHT exit: first clk with mode!=01 SHALL go to AR2 (timer ALLRED_T), then normal sequencing; mode=11 instead goes directly to EMG.
REQ-023 Emergency (mode=11) preemption, effective on next edge: NS_G -> NS_Y, EW_G -> EW_Y (full YELLOW_T), yellow states complete their timer then -> EMG; AR1, AR2, PED_WALK, NIGHT -> EMG immediately.
REQ-024 EMG SHALL hold while mode=11; first clk with mode!=11 SHALL go to AR2 (ALLRED_T), then normal sequencing; pedPending is preserved through EMG.
REQ-025 Priority on simultaneous conditions SHALL be emergency > pedestrian > night > day.
REQ-026 Green SHALL never be shown to both directions, and any green->opposing-green change SHALL pass through yellow and an all-red state.
REQ-027 Unused state encodings SHALL recover to AR2 on the next clk.

Reset
REQ-028 rst=1 on a clk edge SHALL force state=AR2, counter=ALLRED_T-1, flash=1, pedPending=0; outputs ns=100, ew=100, walk=0 from that edge; rst dominates all inputs.
REQ-029 Reset asserted mid-operation (any state, including EMG/PED_WALK) SHALL behave identically to power-on reset.

Verification
REQ-030 Defaults, tick=1 every clk, mode=00, rst released: AR2 1 clk, NS_G 8 clks, NS_Y 3, AR1 1, EW_G 8, EW_Y 3, AR2 1; period 24 clks repeats.
REQ-031 mode=10 for one clk during NS_G: pedPending=1 next clk; after AR1 expiry, PED_WALK 6 clks with walk=1, all red; then EW_G; pedPending=0 from PED_WALK entry.
REQ-032 mode=11 asserted mid NS_G: next clk NS_Y for 3 ticks, then EMG all red; release mode to 00 after 10 clks: AR2 1 clk, then NS_G.
REQ-033 mode=01 held: after next all-red expiry enter NIGHT; ns toggles 010/000 and ew 100/000 each tick starting 010/100; mode=00 -> AR2 then NS_G.
REQ-034 tick=0 held in any state: state and lamps frozen indefinitely; rst pulse in EMG -> AR2, all red, pedPending=0 on next edge.
REQ-035 Illegal state code forced into register: next clk state=AR2, all red.

Source files
------------

// File: rtl/traffic_light_sequencer.sv
// Four-way intersection sequencer with pedestrian, night-flash and emergency modes.
// Moore FSM; lamps are registered from next-state so they change on the same edge as state.
module traffic_light_sequencer #(
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       tick,
  output logic [2:0] nsLight,
  output logic [2:0] ewLight,
  output logic       walk,
  output logic       pedPending,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    NS_G     = 4'd0,
    NS_Y     = 4'd1,
    AR1      = 4'd2,
    EW_G     = 4'd3,
    EW_Y     = 4'd4,
    AR2      = 4'd5,
    PED_WALK = 4'd6,
    NIGHT    = 4'd7,
    EMG      = 4'd8
  } state_t;

  localparam logic [1:0] M_NIGHT = 2'b01;
  localparam logic [1:0] M_PED   = 2'b10;
  localparam logic [1:0] M_EMG   = 2'b11;

  // Plain vector so an out-of-range code can exist and be recovered from.
  logic [3:0] cur;
  logic [3:0] cnt;
  logic       flash;
  logic       ped_ret;   // green to resume after a walk phase: 1 = EW, 0 = NS

  state_t     nxt;
  logic       ret_nxt;
  logic       expire;
  logic       emg;
  logic [3:0] cnt_nxt;
  logic       flash_nxt;
  logic       ped_nxt;
  logic [6:0] lamps_nxt;

  function automatic logic [3:0] dur(state_t s);
    case (s)
      NS_G, EW_G: return 4'(GREEN_T - 1);
      NS_Y, EW_Y: return 4'(YELLOW_T - 1);
      AR1, AR2:   return 4'(ALLRED_T - 1);
      PED_WALK:   return 4'(WALK_T - 1);
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic [6:0] decode(state_t s, logic f);
    case (s)
      NS_G:     return {3'b001, 3'b100, 1'b0};
      NS_Y:     return {3'b010, 3'b100, 1'b0};
      EW_G:     return {3'b100, 3'b001, 1'b0};
      EW_Y:     return {3'b100, 3'b010, 1'b0};
      PED_WALK: return {3'b100, 3'b100, 1'b1};
      NIGHT:    return {(f ? 3'b010 : 3'b000), (f ? 3'b100 : 3'b000), 1'b0};
      default:  return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  always_comb begin
    expire  = tick && (cnt == 4'd0);
    emg     = (mode == M_EMG);
    nxt     = state_t'(cur);
    ret_nxt = ped_ret;
    case (cur)
      NS_G:     if (emg || expire) nxt = NS_Y;
      NS_Y:     if (expire) nxt = emg ? EMG : AR1;
      EW_G:     if (emg || expire) nxt = EW_Y;
      EW_Y:     if (expire) nxt = emg ? EMG : AR2;
      AR1, AR2: begin
        if (emg) nxt = EMG;
        else if (expire) begin
          if (pedPending) begin
            nxt     = PED_WALK;
            ret_nxt = (cur == AR1);
          end else if (mode == M_NIGHT) nxt = NIGHT;
          else nxt = (cur == AR1) ? EW_G : NS_G;
        end
      end
      PED_WALK: begin
        if (emg) nxt = EMG;
        else if (expire) nxt = ped_ret ? EW_G : NS_G;
      end
      NIGHT: begin
        if (emg) nxt = EMG;
        else if (mode != M_NIGHT) nxt = AR2;
      end
      EMG:      if (!emg) nxt = AR2;
      default:  nxt = AR2;
    endcase

    if (4'(nxt) != cur)         cnt_nxt = dur(nxt);
    else if (tick && cnt != 0)  cnt_nxt = cnt - 4'd1;
    else                        cnt_nxt = cnt;

    if (nxt == NIGHT && cur != NIGHT) flash_nxt = 1'b1;
    else if (cur == NIGHT && tick)    flash_nxt = ~flash;
    else                              flash_nxt = flash;

    if (nxt == PED_WALK && cur != PED_WALK)  ped_nxt = 1'b0;
    else if (mode == M_PED && cur != PED_WALK) ped_nxt = 1'b1;
    else                                     ped_nxt = pedPending;

    lamps_nxt = decode(nxt, flash_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= AR2;
      cnt        <= 4'(ALLRED_T - 1);
      flash      <= 1'b1;
      ped_ret    <= 1'b0;
      pedPending <= 1'b0;
      nsLight    <= 3'b100;
      ewLight    <= 3'b100;
      walk       <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      flash      <= flash_nxt;
      ped_ret    <= ret_nxt;
      pedPending <= ped_nxt;
      nsLight    <= lamps_nxt[6:4];
      ewLight    <= lamps_nxt[3:1];
      walk       <= lamps_nxt[0];
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench: a behavioural elapsed-tick model predicts each cycle's outputs.
module tb_traffic_light_sequencer;

  localparam int G = 8, Y = 3, R = 1, W = 6;
  localparam logic [3:0] S_NS_G = 4'd0, S_NS_Y = 4'd1, S_AR1 = 4'd2, S_EW_G = 4'd3,
                         S_EW_Y = 4'd4, S_AR2 = 4'd5, S_PED = 4'd6, S_NIGHT = 4'd7,
                         S_EMG = 4'd8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       tick = 1'b1;
  logic [2:0] ns, ew;
  logic       walk, ped_pending;
  logic [3:0] state;

  traffic_light_sequencer #(.GREEN_T(G), .YELLOW_T(Y), .ALLRED_T(R), .WALK_T(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .tick(tick),
    .nsLight(ns), .ewLight(ew), .walk(walk), .pedPending(ped_pending), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] lamps;
    logic       ped;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  logic [3:0] m_st = S_AR2;
  int         m_el = 0;
  logic       m_flash = 1'b1, m_ped = 1'b0, m_ret = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int dur_of(input logic [3:0] s);
    case (s)
      S_NS_G, S_EW_G: return G;
      S_NS_Y, S_EW_Y: return Y;
      S_AR1, S_AR2:   return R;
      S_PED:          return W;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [6:0] exp_lamps(input logic [3:0] s, input logic f);
    logic [2:0] n3, e3;
    logic       w;
    n3 = 3'b100; e3 = 3'b100; w = 1'b0;
    if (s == S_NS_G) n3 = 3'b001;
    if (s == S_NS_Y) n3 = 3'b010;
    if (s == S_EW_G) e3 = 3'b001;
    if (s == S_EW_Y) e3 = 3'b010;
    if (s == S_PED)  w = 1'b1;
    if (s == S_NIGHT) begin
      n3 = f ? 3'b010 : 3'b000;
      e3 = f ? 3'b100 : 3'b000;
    end
    return {n3, e3, w};
  endfunction

  task automatic model_step(input logic r, input logic [1:0] md, input logic tk);
    logic [3:0] o, n;
    logic       fin, em;
    if (r) begin
      m_st = S_AR2; m_el = 0; m_flash = 1'b1; m_ped = 1'b0;
      return;
    end
    o   = m_st;
    n   = o;
    em  = (md == 2'b11);
    fin = tk && (m_el + 1 == dur_of(o));
    case (o)
      S_NS_G: if (em || fin) n = S_NS_Y;
      S_EW_G: if (em || fin) n = S_EW_Y;
      S_NS_Y: if (fin) n = em ? S_EMG : S_AR1;
      S_EW_Y: if (fin) n = em ? S_EMG : S_AR2;
      S_AR1, S_AR2: begin
        if (em) n = S_EMG;
        else if (fin && m_ped) begin n = S_PED; m_ret = (o == S_AR1); end
        else if (fin && md == 2'b01) n = S_NIGHT;
        else if (fin) n = (o == S_AR1) ? S_EW_G : S_NS_G;
      end
      S_PED:   if (em) n = S_EMG; else if (fin) n = m_ret ? S_EW_G : S_NS_G;
      S_NIGHT: if (em) n = S_EMG; else if (md != 2'b01) n = S_AR2;
      S_EMG:   if (!em) n = S_AR2;
      default: n = S_AR2;
    endcase
    if (n == S_PED && o != S_PED) m_ped = 1'b0;
    else if (md == 2'b10 && o != S_PED) m_ped = 1'b1;
    if (n == S_NIGHT && o != S_NIGHT) m_flash = 1'b1;
    else if (o == S_NIGHT && tk) m_flash = ~m_flash;
    if (n != o) m_el = 0;
    else if (tk) m_el++;
    m_st = n;
  endtask

  task automatic step(input logic r, input logic [1:0] md, input logic tk);
    exp_t e;
    @(negedge clk);
    rst = r; mode = md; tick = tk;
    model_step(r, md, tk);
    e.st = m_st; e.lamps = exp_lamps(m_st, m_flash); e.ped = m_ped;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("lamps", 32'({ns, ew, walk}), 32'(e.lamps));
      chk("ped_pending", 32'(ped_pending), 32'(e.ped));
      chk("dual_green", 32'(ns[0] & ew[0]), 32'd0);
    end
  endtask

  task automatic wait_for(input logic [3:0] target, input logic [1:0] md);
    for (int i = 0; i < 60 && state != target; i++) step(1'b0, md, 1'b1);
    chk("reach_state", 32'(state), 32'(target));
  endtask

  initial begin
    int e1, e2, gl, wc;
    logic [3:0] prev, frozen;

    step(1'b1, 2'b00, 1'b1);
    step(1'b1, 2'b00, 1'b1);
    chk("reset_state", 32'(state), 32'(S_AR2));
    chk("reset_lamps", 32'({ns, ew, walk}), 32'b1001000);
    chk("reset_ped", 32'(ped_pending), 32'd0);

    // Day cycle: period between NS_G entries and NS_G dwell time
    e1 = -1; e2 = -1; gl = 0;
    for (int i = 0; i < 60; i++) begin
      prev = state;
      step(1'b0, 2'b00, 1'b1);
      if (prev != S_NS_G && state == S_NS_G) begin
        if (e1 < 0) e1 = cyc; else if (e2 < 0) e2 = cyc;
      end
      if (e2 < 0 && e1 >= 0 && state == S_NS_G) gl++;
    end
    chk("day_period", 32'(e2 - e1), 32'd24);
    chk("ns_green_len", 32'(gl), 32'd8);

    // Pedestrian request during NS_G
    wait_for(S_NS_G, 2'b00);
    step(1'b0, 2'b10, 1'b1);
    chk("ped_latched", 32'(ped_pending), 32'd1);
    wc = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 2'b00, 1'b1);
      if (walk) wc++;
    end
    chk("walk_len", 32'(wc), 32'd6);

    // Emergency mid NS_G
    wait_for(S_NS_G, 2'b00);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b11, 1'b1);
    chk("emg_to_yellow", 32'(state), 32'(S_NS_Y));
    for (int i = 0; i < 12; i++) step(1'b0, 2'b11, 1'b1);
    chk("emg_hold", 32'(state), 32'(S_EMG));
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b1);

    // Night flash then return
    for (int i = 0; i < 40; i++) step(1'b0, 2'b01, 1'b1);
    chk("night_entered", 32'(state), 32'(S_NIGHT));
    for (int i = 0; i < 12; i++) step(1'b0, 2'b00, 1'b1);

    // Freeze with tick low
    frozen = state;
    for (int i = 0; i < 12; i++) step(1'b0, 2'b00, 1'b0);
    chk("freeze", 32'(state), 32'(frozen));

    // Reset pulse while in EMG with a pending pedestrian request
    step(1'b0, 2'b10, 1'b1);
    wait_for(S_EMG, 2'b11);
    step(1'b0, 2'b11, 1'b1);
    chk("ped_kept_in_emg", 32'(ped_pending), 32'd1);
    step(1'b1, 2'b11, 1'b1);
    chk("rst_in_emg", 32'({state, ns, ew, ped_pending}), 32'({S_AR2, 3'b100, 3'b100, 1'b0}));

    // Illegal encoding forced into the state register
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b1);
    #2;
    force dut.cur = 4'hF;
    #1;
    release dut.cur;
    chk("forced_code", 32'(state), 32'hF);
    m_st = 4'hF;
    step(1'b0, 2'b00, 1'b1);
    chk("illegal_recover", 32'(state), 32'(S_AR2));

    // Random modes held for random spans, ragged tick, rare reset
    for (int i = 0; i < 60; i++) begin
      logic [1:0] md;
      int span;
      md = 2'($urandom_range(0, 3));
      span = $urandom_range(1, 12);
      for (int j = 0; j < span; j++)
        step(($urandom_range(0, 99) == 0), md, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
